rename_map_table: RTL and testbench
===================================

// Module: rename_map_table
// PURPOSE
// - 2-way register alias table for the dispatch stage; consumes freelist dout0/dout1, produces renamed operands for RS/ROB.
// - Holds speculative map (SMT, written at dispatch) and architectural map (AMT, written at retire).
// - Returns old mapping (told) per slot; ROB frees it to the freelist at retire.
// - rollback_en copies AMT into SMT in one cycle, in step with freelist rollback.
// PARAMETERS
// - AREG_NUM        32  architectural registers (x0..x31)
// - AREG_IDX_WIDTH  5   arch register index width
// - PREG_IDX_WIDTH  6   physical register index width (`PREG_IDX_WIDTH)
// - ZERO_PREG       0   physical register permanently bound to x0 (`ZERO_PREG)
// PORTS
// - clock        in   1    clock; all state on posedge
// - reset        in   1    reset, synchronous, active-high
// - rollback_en  in   1    mispredict recovery: SMT <= AMT
// - dp_stall     in   1    dispatch blocked this cycle; SMT not written
// - dp_valid0/1  in   1    slot instruction valid
// - rd_wr0/1     in   1    slot writes a destination register
// - ars1_0/1, ars2_0/1, ard0/1  in  AREG_IDX_WIDTH  slot source/dest arch regs
// - fl_preg0/1   in   PREG_IDX_WIDTH  freelist dout0/dout1
// - fl_rd_en0/1  out  1    freelist rd_en0/rd_en1
// - prs1_0/1, prs2_0/1  out  PREG_IDX_WIDTH  renamed sources
// - prd0/1       out  PREG_IDX_WIDTH  new dest preg (ZERO_PREG if none)
// - told0/1      out  PREG_IDX_WIDTH  previous mapping of ard (ZERO_PREG if none)
// - rt_en0/1     in   1    ROB retires slot (slot0 older)
// - rt_ard0/1    in   AREG_IDX_WIDTH  retiring arch dest
// - rt_prd0/1    in   PREG_IDX_WIDTH  retiring phys dest
// BEHAVIOUR
// - Reset: SMT[i] = AMT[i] = i for all i; lines up with freelist reset contents 32+i.
// - Reset has priority over rollback, dispatch and retire.
// - Outputs are combinational from tables and inputs; no registered outputs, lookup latency 0.
// - alloc_k = dp_valid_k & rd_wr_k & (ard_k != 0); fl_rd_en_k = alloc_k.
//   fl_rd_en_k is not gated by dp_stall; freelist gates internally.
// - prd_k = alloc_k ? fl_preg_k : ZERO_PREG.
// - Slot0 lookups: prs1_0 = SMT[ars1_0], prs2_0 = SMT[ars2_0].
// - Slot0 dest: told0 = alloc0 ? SMT[ard0] : ZERO_PREG.
// - Slot1 intra-group bypass: source == ard0 with alloc0 -> prd0, else SMT lookup.
// - Slot1 told: told1 = (alloc0 & ard1==ard0) ? prd0 : SMT[ard1]; ZERO_PREG if !alloc1.
// - Source x0 always yields ZERO_PREG; SMT[0]/AMT[0] never written.
// - Dispatch write, only when !dp_stall & !rollback_en:
//   SMT[ard0] <= prd0 if alloc0; SMT[ard1] <= prd1 if alloc1.
//   If ard0==ard1, slot1 value wins.
// - Retire write: AMT[rt_ard_k] <= rt_prd_k if rt_en_k & rt_ard_k != 0.
//   Same areg on both slots: slot1 wins. Retire is independent of dp_stall and of rollback.
// - Rollback: SMT <= AMT_next, i.e. AMT including this cycle's retire writes; dispatch writes discarded.
//   Outputs in the rollback cycle are still driven, but downstream ignores them.
// - No handshake back-pressure. Dispatch logic guarantees freelist non-empty before asserting dp_valid.
// TESTING
// - Reset, slot0 reads x5 -> prs1_0=5; slot0 alloc x5 with fl_preg0=32 -> prd0=32, told0=5, next read of x5 -> 32.
// - Both slots: ard0=x3 (fl 40), slot1 ars1=x3, ard1=x3 (fl 41) -> prs1_1=40, told1=40; then SMT[3]=41.
// - dp_stall=1 with alloc on x7 (fl 33) -> fl_rd_en0=1, prd0=33, SMT[7] unchanged (still 7) next cycle.
// - ard=x0, rd_wr=1 -> fl_rd_en=0, prd=told=0; ars1=x0 after any traffic -> prs1=0.
// - Rename x9->45, retire x9/45 on rt slot0, x10->50 dispatched and not retired, rollback -> SMT[9]=45, SMT[10]=10.
// - Rollback same cycle as retire (x4->60) and dispatch (x4->61) -> SMT[4]=60, AMT[4]=60.

Source files
------------

// File: rtl/rename_map_table_if.sv
// Dispatch/retire-side bundle of the register alias table.
// The master modport belongs to dispatch/ROB/freelist glue, and the slave modport belongs to the table.
interface rename_map_table_if #(
    parameter int AREG_IDX_WIDTH = 5,
    parameter int PREG_IDX_WIDTH = 6
);
    // Control
    logic                      rollback_en;
    logic                      dp_stall;

    // Dispatch slot 0 / slot 1
    logic                      dp_valid0, dp_valid1;
    logic                      rd_wr0,    rd_wr1;
    logic [AREG_IDX_WIDTH-1:0] ars1_0, ars1_1;
    logic [AREG_IDX_WIDTH-1:0] ars2_0, ars2_1;
    logic [AREG_IDX_WIDTH-1:0] ard0,   ard1;
    logic [PREG_IDX_WIDTH-1:0] fl_preg0, fl_preg1;

    // Freelist pops and renamed operands
    logic                      fl_rd_en0, fl_rd_en1;
    logic [PREG_IDX_WIDTH-1:0] prs1_0, prs1_1;
    logic [PREG_IDX_WIDTH-1:0] prs2_0, prs2_1;
    logic [PREG_IDX_WIDTH-1:0] prd0,   prd1;
    logic [PREG_IDX_WIDTH-1:0] told0,  told1;

    // Retire slot 0 (older) / slot 1
    logic                      rt_en0,  rt_en1;
    logic [AREG_IDX_WIDTH-1:0] rt_ard0, rt_ard1;
    logic [PREG_IDX_WIDTH-1:0] rt_prd0, rt_prd1;

    modport master (
        output rollback_en, dp_stall,
        output dp_valid0, dp_valid1, rd_wr0, rd_wr1,
        output ars1_0, ars1_1, ars2_0, ars2_1, ard0, ard1,
        output fl_preg0, fl_preg1,
        output rt_en0, rt_en1, rt_ard0, rt_ard1, rt_prd0, rt_prd1,
        input  fl_rd_en0, fl_rd_en1,
        input  prs1_0, prs1_1, prs2_0, prs2_1, prd0, prd1, told0, told1
    );

    modport slave (
        input  rollback_en, dp_stall,
        input  dp_valid0, dp_valid1, rd_wr0, rd_wr1,
        input  ars1_0, ars1_1, ars2_0, ars2_1, ard0, ard1,
        input  fl_preg0, fl_preg1,
        input  rt_en0, rt_en1, rt_ard0, rt_ard1, rt_prd0, rt_prd1,
        output fl_rd_en0, fl_rd_en1,
        output prs1_0, prs1_1, prs2_0, prs2_1, prd0, prd1, told0, told1
    );
endinterface

// File: rtl/rename_map_table.sv
// Two-way register alias table.
// The speculative map (SMT) is written at dispatch, and the architectural map (AMT) is written at retire.
// Lookups are combinational. Slot 1 sees slot 0's new mapping through an intra-group bypass.
// A rollback reloads SMT from AMT, including the retire writes of the same cycle.
module rename_map_table #(
    parameter int AREG_NUM       = 32,
    parameter int AREG_IDX_WIDTH = 5,
    parameter int PREG_IDX_WIDTH = 6,
    parameter int ZERO_PREG      = 0
) (
    input  logic               clock,
    input  logic               reset,
    rename_map_table_if.slave  rmt
);
    localparam logic [PREG_IDX_WIDTH-1:0] ZERO = PREG_IDX_WIDTH'(ZERO_PREG);

    typedef logic [PREG_IDX_WIDTH-1:0] preg_t;
    typedef logic [AREG_IDX_WIDTH-1:0] areg_t;

    preg_t r_smt [AREG_NUM];
    preg_t r_amt [AREG_NUM];
    preg_t w_amt_next [AREG_NUM];

    logic  w_alloc0, w_alloc1;
    preg_t w_prd0, w_prd1;

    // Slot 0 lookup: x0 is hard-wired to the zero preg and never comes from the table.
    function automatic preg_t smt_rd(input areg_t ar);
        return (ar == '0) ? ZERO : r_smt[ar];
    endfunction

    // Slot 1 lookup: a slot 0 rename in the same group shadows the table entry.
    function automatic preg_t smt_rd_byp(input areg_t ar);
        if (ar == '0)
            return ZERO;
        if (w_alloc0 && (ar == rmt.ard0))
            return w_prd0;
        return r_smt[ar];
    endfunction

    // A slot allocates only for a real destination. x0 never consumes a freelist entry.
    // The freelist pop is not gated by dp_stall, because the freelist applies the stall itself.
    assign w_alloc0 = rmt.dp_valid0 & rmt.rd_wr0 & (rmt.ard0 != '0);
    assign w_alloc1 = rmt.dp_valid1 & rmt.rd_wr1 & (rmt.ard1 != '0);
    assign w_prd0   = w_alloc0 ? rmt.fl_preg0 : ZERO;
    assign w_prd1   = w_alloc1 ? rmt.fl_preg1 : ZERO;

    assign rmt.fl_rd_en0 = w_alloc0;
    assign rmt.fl_rd_en1 = w_alloc1;
    assign rmt.prd0      = w_prd0;
    assign rmt.prd1      = w_prd1;

    assign rmt.prs1_0 = smt_rd(rmt.ars1_0);
    assign rmt.prs2_0 = smt_rd(rmt.ars2_0);
    assign rmt.prs1_1 = smt_rd_byp(rmt.ars1_1);
    assign rmt.prs2_1 = smt_rd_byp(rmt.ars2_1);

    assign rmt.told0 = w_alloc0 ? r_smt[rmt.ard0] : ZERO;
    assign rmt.told1 = w_alloc1 ? smt_rd_byp(rmt.ard1) : ZERO;

    // Next AMT after this cycle's retires. Slot 1 is younger, so its write lands last.
    // A rollback in this cycle also loads SMT from this value.
    always_comb begin
        // NOTE: the whole array is defaulted first so no entry is left unassigned (no latch).
        w_amt_next = r_amt;
        if (rmt.rt_en0 && (rmt.rt_ard0 != '0))
            w_amt_next[rmt.rt_ard0] = rmt.rt_prd0;
        if (rmt.rt_en1 && (rmt.rt_ard1 != '0))
            w_amt_next[rmt.rt_ard1] = rmt.rt_prd1;
    end

    // Table state: reset, then retire, rollback, and dispatch updates.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the tables must come out of reset as an identity map that matches the freelist.
            // That is why this memory is reset, and a plain RAM would not do.
            for (int i = 0; i < AREG_NUM; i++) begin
                r_smt[i] <= PREG_IDX_WIDTH'(i);
                r_amt[i] <= PREG_IDX_WIDTH'(i);
            end
        end else begin
            // NOTE: non-blocking writes let the second slot 1 write override slot 0 on the same areg.
            r_amt <= w_amt_next;
            if (rmt.rollback_en) begin
                r_smt <= w_amt_next;
            end else if (!rmt.dp_stall) begin
                if (w_alloc0)
                    r_smt[rmt.ard0] <= w_prd0;
                if (w_alloc1)
                    r_smt[rmt.ard1] <= w_prd1;
            end
        end
    end
endmodule

// File: tb/tb_rename_map_table.sv
// Directed bench for rename_map_table.
// Expected values are computed by hand from the identity reset map and the stimulus applied.
module tb_rename_map_table;
    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;

    rename_map_table_if #(.AREG_IDX_WIDTH(5), .PREG_IDX_WIDTH(6)) u_if ();

    rename_map_table #(
        .AREG_NUM(32), .AREG_IDX_WIDTH(5), .PREG_IDX_WIDTH(6), .ZERO_PREG(0)
    ) u_dut (
        .clock (clock),
        .reset (reset),
        .rmt   (u_if.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        u_if.rollback_en = 1'b0;  u_if.dp_stall  = 1'b0;
        u_if.dp_valid0   = 1'b0;  u_if.dp_valid1 = 1'b0;
        u_if.rd_wr0      = 1'b0;  u_if.rd_wr1    = 1'b0;
        u_if.ars1_0 = 5'd0; u_if.ars1_1 = 5'd0;
        u_if.ars2_0 = 5'd0; u_if.ars2_1 = 5'd0;
        u_if.ard0   = 5'd0; u_if.ard1   = 5'd0;
        u_if.fl_preg0 = 6'd0; u_if.fl_preg1 = 6'd0;
        u_if.rt_en0 = 1'b0;  u_if.rt_en1 = 1'b0;
        u_if.rt_ard0 = 5'd0; u_if.rt_ard1 = 5'd0;
        u_if.rt_prd0 = 6'd0; u_if.rt_prd1 = 6'd0;
    endtask

    // Read the current SMT entry through the slot 0 source port.
    task automatic lookup(input string tag, input logic [4:0] ar, input logic [5:0] exp);
        idle();
        u_if.ars1_0 = ar;
        #1;
        check(tag, 32'(u_if.prs1_0), 32'(exp));
    endtask

    task automatic dispatch0(input logic [4:0] ard, input logic [5:0] fl);
        u_if.dp_valid0 = 1'b1; u_if.rd_wr0 = 1'b1; u_if.ard0 = ard; u_if.fl_preg0 = fl;
    endtask

    task automatic dispatch1(input logic [4:0] ard, input logic [5:0] fl);
        u_if.dp_valid1 = 1'b1; u_if.rd_wr1 = 1'b1; u_if.ard1 = ard; u_if.fl_preg1 = fl;
    endtask

    task automatic do_rollback();
        idle();
        u_if.rollback_en = 1'b1;
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset identity map
        lookup("rst_x5", 5'd5, 6'd5);
        lookup("rst_x31", 5'd31, 6'd31);
        lookup("rst_x0", 5'd0, 6'd0);

        // Slot 0 rename x5 -> 32
        idle();
        dispatch0(5'd5, 6'd32);
        u_if.ars1_0 = 5'd5;
        u_if.ars2_0 = 5'd31;
        #1;
        check("s0_prs1_old", 32'(u_if.prs1_0), 32'd5);
        check("s0_prs2", 32'(u_if.prs2_0), 32'd31);
        check("s0_prd", 32'(u_if.prd0), 32'd32);
        check("s0_told", 32'(u_if.told0), 32'd5);
        check("s0_flrd0", 32'(u_if.fl_rd_en0), 32'd1);
        check("s0_flrd1", 32'(u_if.fl_rd_en1), 32'd0);
        check("s1_idle_prd", 32'(u_if.prd1), 32'd0);
        tick();
        lookup("x5_new", 5'd5, 6'd32);

        // Both slots on x3: slot 1 bypasses slot 0's rename, and slot 1 wins the write
        idle();
        dispatch0(5'd3, 6'd40);
        dispatch1(5'd3, 6'd41);
        u_if.ars1_0 = 5'd3;
        u_if.ars1_1 = 5'd3;
        u_if.ars2_1 = 5'd5;
        #1;
        check("grp_prs1_0", 32'(u_if.prs1_0), 32'd3);
        check("grp_told0", 32'(u_if.told0), 32'd3);
        check("grp_prs1_1_byp", 32'(u_if.prs1_1), 32'd40);
        check("grp_prs2_1_smt", 32'(u_if.prs2_1), 32'd32);
        check("grp_told1_byp", 32'(u_if.told1), 32'd40);
        check("grp_prd1", 32'(u_if.prd1), 32'd41);
        check("grp_flrd1", 32'(u_if.fl_rd_en1), 32'd1);
        tick();
        lookup("x3_slot1_wins", 5'd3, 6'd41);

        // The stall still pops the freelist but leaves SMT untouched
        idle();
        u_if.dp_stall = 1'b1;
        dispatch0(5'd7, 6'd33);
        #1;
        check("stall_flrd0", 32'(u_if.fl_rd_en0), 32'd1);
        check("stall_prd0", 32'(u_if.prd0), 32'd33);
        check("stall_told0", 32'(u_if.told0), 32'd7);
        tick();
        lookup("stall_x7", 5'd7, 6'd7);

        // x0 destinations and sources
        idle();
        dispatch0(5'd0, 6'd34);
        dispatch1(5'd0, 6'd35);
        #1;
        check("x0_flrd0", 32'(u_if.fl_rd_en0), 32'd0);
        check("x0_flrd1", 32'(u_if.fl_rd_en1), 32'd0);
        check("x0_prd0", 32'(u_if.prd0), 32'd0);
        check("x0_told0", 32'(u_if.told0), 32'd0);
        check("x0_prd1", 32'(u_if.prd1), 32'd0);
        check("x0_told1", 32'(u_if.told1), 32'd0);
        check("x0_prs1_1", 32'(u_if.prs1_1), 32'd0);
        tick();
        lookup("x0_src", 5'd0, 6'd0);
        lookup("x5_kept", 5'd5, 6'd32);

        // Slot 0 without a destination does not bypass into slot 1
        idle();
        u_if.dp_valid0 = 1'b1;
        u_if.ard0 = 5'd5;
        dispatch1(5'd6, 6'd22);
        u_if.ars1_1 = 5'd5;
        #1;
        check("nobyp_prd0", 32'(u_if.prd0), 32'd0);
        check("nobyp_told0", 32'(u_if.told0), 32'd0);
        check("nobyp_prs1_1", 32'(u_if.prs1_1), 32'd32);
        check("nobyp_told1", 32'(u_if.told1), 32'd6);
        tick();
        lookup("x6_new", 5'd6, 6'd22);

        // Rename x9 -> 45, then x10 -> 50 while x9/45 retires, then roll back
        idle();
        dispatch0(5'd9, 6'd45);
        tick();
        idle();
        dispatch0(5'd10, 6'd50);
        u_if.rt_en0 = 1'b1; u_if.rt_ard0 = 5'd9; u_if.rt_prd0 = 6'd45;
        tick();
        lookup("pre_rb_x10", 5'd10, 6'd50);
        do_rollback();
        lookup("rb_x9", 5'd9, 6'd45);
        lookup("rb_x10", 5'd10, 6'd10);
        lookup("rb_x5", 5'd5, 6'd5);
        lookup("rb_x3", 5'd3, 6'd3);

        // Rollback, retire x4 -> 60, and dispatch x4 -> 61 in the same cycle
        idle();
        u_if.rollback_en = 1'b1;
        u_if.rt_en0 = 1'b1; u_if.rt_ard0 = 5'd4; u_if.rt_prd0 = 6'd60;
        dispatch0(5'd4, 6'd61);
        tick();
        lookup("rbrt_smt_x4", 5'd4, 6'd60);
        do_rollback();
        lookup("rbrt_amt_x4", 5'd4, 6'd60);

        // Dual retire on one areg (slot 1 wins), then retire x0 (ignored) while dispatch is stalled
        idle();
        u_if.rt_en0 = 1'b1; u_if.rt_ard0 = 5'd12; u_if.rt_prd0 = 6'd20;
        u_if.rt_en1 = 1'b1; u_if.rt_ard1 = 5'd12; u_if.rt_prd1 = 6'd21;
        tick();
        idle();
        u_if.dp_stall = 1'b1;
        u_if.rt_en0 = 1'b1; u_if.rt_ard0 = 5'd0;  u_if.rt_prd0 = 6'd55;
        u_if.rt_en1 = 1'b1; u_if.rt_ard1 = 5'd14; u_if.rt_prd1 = 6'd24;
        tick();
        lookup("rt_smt_unchanged", 5'd12, 6'd12);
        do_rollback();
        lookup("rt_dual_x12", 5'd12, 6'd21);
        lookup("rt_x0_ignored", 5'd0, 6'd0);
        lookup("rt_stalled_x14", 5'd14, 6'd24);

        // Reset wins over a concurrent dispatch and retire
        idle();
        reset = 1'b1;
        dispatch0(5'd13, 6'd30);
        u_if.rt_en0 = 1'b1; u_if.rt_ard0 = 5'd13; u_if.rt_prd0 = 6'd30;
        tick();
        reset = 1'b0;
        lookup("rst2_x13", 5'd13, 6'd13);
        lookup("rst2_x12", 5'd12, 6'd12);
        do_rollback();
        lookup("rst2_amt_x14", 5'd14, 6'd14);
        lookup("rst2_amt_x13", 5'd13, 6'd13);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
